// File: rtl/fei4_rx_frame_arbiter.sv
// fei4_rx_frame_arbiter
// NCH decoded 8b10b byte streams are framed (SOF K28.7 0xFC / EOF K28.5 0xBC)
// into 24-bit records, buffered per channel and merged round-robin into one
// 32-bit first-word-fall-through output {DATA_IDENTIFIER, channel, record}.
// Optional feature: define FEI4_RX_FRAME_LOST_CNT_EN to build the per-channel
// saturating dropped-record counters; otherwise LOST_COUNT reads as zero.
module fei4_rx_frame_arbiter #(
  parameter int         NCH             = 4,
  parameter int         DEPTH           = 16,
  parameter logic [3:0] DATA_IDENTIFIER = 4'd0
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  input  logic [8*NCH-1:0] RX_BYTE,
  input  logic [NCH-1:0]   RX_K,
  input  logic [NCH-1:0]   RX_VALID,
  input  logic [NCH-1:0]   RX_ENABLE,
  input  logic             ERR_CLR,
  input  logic             FIFO_READ,
  output logic             FIFO_EMPTY,
  output logic [31:0]      FIFO_DATA,
  output logic [NCH-1:0]   RX_FIFO_FULL,
  output logic [NCH-1:0]   RX_FIFO_OVERFLOW_ERR,
  output logic [NCH-1:0]   RX_FRAME_ERR,
  output logic [8*NCH-1:0] LOST_COUNT
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;
  localparam logic [7:0] K_SOF   = 8'hFC;
  localparam logic [7:0] K_EOF   = 8'hBC;

  // Per-channel assembler state
  logic [0:0]     r_state [NCH];
  logic [1:0]     r_idx   [NCH];
  logic [15:0]    r_rec   [NCH];
  // Per-channel record buffers
  logic [23:0]    r_mem   [NCH][DEPTH];
  logic [PW-1:0]  r_wptr  [NCH];
  logic [PW-1:0]  r_rptr  [NCH];
  logic [CW-1:0]  r_count [NCH];
  logic [NCH-1:0] r_full;
  logic [NCH-1:0] r_ovf;
  logic [NCH-1:0] r_ferr;
  // Output stage and arbiter
  logic [CHW-1:0] r_last;
  logic           r_out_valid;
  logic [31:0]    r_out_data;

  logic [0:0]     w_nstate   [NCH];
  logic [1:0]     w_nidx     [NCH];
  logic [15:0]    w_nrec     [NCH];
  logic [23:0]    w_push_rec [NCH];
  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_push_ok;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_ferr_evt;
  logic [NCH-1:0] w_ovf_evt;
  logic           w_load;
  logic           w_gnt_found;
  logic [CHW-1:0] w_gnt_ch;
  logic [CHW-1:0] w_cand;

  // Framing FSM next-state: SOF opens a frame, every third data byte emits a record
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_nstate[i]   = r_state[i];
      w_nidx[i]     = r_idx[i];
      w_nrec[i]     = r_rec[i];
      w_push[i]     = 1'b0;
      w_push_rec[i] = '0;
      w_ferr_evt[i] = 1'b0;
      if (!RX_ENABLE[i]) begin
        w_nstate[i] = ST_IDLE;
        w_nidx[i]   = 2'd0;
      end else if (RX_VALID[i]) begin
        if (r_state[i] == ST_IDLE) begin
          if (RX_K[i] && RX_BYTE[8*i +: 8] == K_SOF) begin
            w_nstate[i] = ST_DATA;
            w_nidx[i]   = 2'd0;
          end
        end else if (!RX_K[i]) begin
          if (r_idx[i] == 2'd2) begin
            w_push[i]     = 1'b1;
            w_push_rec[i] = {r_rec[i], RX_BYTE[8*i +: 8]};
            w_nidx[i]     = 2'd0;
          end else begin
            w_nrec[i] = {r_rec[i][7:0], RX_BYTE[8*i +: 8]};
            w_nidx[i] = r_idx[i] + 2'd1;
          end
        end else begin
          // Any K inside a frame ends the partial record; only a clean boundary is legal
          w_nidx[i]     = 2'd0;
          w_ferr_evt[i] = (r_idx[i] != 2'd0);
          if (RX_BYTE[8*i +: 8] == K_SOF) begin
            w_nstate[i] = ST_DATA;
          end else if (RX_BYTE[8*i +: 8] == K_EOF) begin
            w_nstate[i] = ST_IDLE;
          end else begin
            w_nstate[i]   = ST_IDLE;
            w_ferr_evt[i] = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin grant starting after the last served channel; push accept/drop decision
  always_comb begin
    w_load      = !r_out_valid || FIFO_READ;
    w_gnt_found = 1'b0;
    w_gnt_ch    = '0;
    w_cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = CHW'((int'(r_last) + 1 + k) % NCH);
      if (!w_gnt_found && r_count[w_cand] != '0) begin
        w_gnt_found = 1'b1;
        w_gnt_ch    = w_cand;
      end
    end
    w_pop = '0;
    if (w_load && w_gnt_found) w_pop[w_gnt_ch] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      // A full buffer still accepts when the same channel is drained this cycle
      w_push_ok[i] = w_push[i] && (r_count[i] != CW'(DEPTH) || w_pop[i]);
      w_ovf_evt[i] = w_push[i] && !w_push_ok[i];
    end
  end

  // Assembler state, buffer pointers/counts, full and sticky error flags
  always_ff @(posedge BUS_CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (BUS_RST) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_IDLE;
        r_idx[i]   <= 2'd0;
        r_rec[i]   <= '0;
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_full <= '0;
      r_ovf  <= '0;
      r_ferr <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_nstate[i];
        r_idx[i]   <= w_nidx[i];
        r_rec[i]   <= w_nrec[i];
        if (w_push_ok[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])     r_rptr[i] <= r_rptr[i] + PW'(1);
        r_count[i] <= r_count[i] + CW'(w_push_ok[i]) - CW'(w_pop[i]);
        r_full[i]  <= (r_count[i] == CW'(DEPTH));
        // A new event in the clear cycle survives the clear
        r_ovf[i]   <= ERR_CLR ? w_ovf_evt[i]  : (r_ovf[i]  | w_ovf_evt[i]);
        r_ferr[i]  <= ERR_CLR ? w_ferr_evt[i] : (r_ferr[i] | w_ferr_evt[i]);
      end
    end
  end

  // Record storage write port
  always_ff @(posedge BUS_CLK) begin
    // NOTE: the storage array has no reset; pointers and counts define which entries are valid.
    for (int i = 0; i < NCH; i++) begin
      if (w_push_ok[i]) r_mem[i][r_wptr[i]] <= w_push_rec[i];
    end
  end

  // Single-entry output register, reloaded whenever empty or being popped
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_last      <= CHW'(NCH - 1);
    end else if (w_load) begin
      r_out_valid <= w_gnt_found;
      if (w_gnt_found) begin
        r_out_data <= {DATA_IDENTIFIER, 4'(w_gnt_ch), r_mem[w_gnt_ch][r_rptr[w_gnt_ch]]};
        r_last     <= w_gnt_ch;
      end
    end
  end

`ifdef FEI4_RX_FRAME_LOST_CNT_EN
  logic [7:0] r_lost [NCH];

  // Saturating dropped-record counters
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      for (int i = 0; i < NCH; i++) r_lost[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ERR_CLR)                                 r_lost[i] <= w_ovf_evt[i] ? 8'd1 : 8'd0;
        else if (w_ovf_evt[i] && r_lost[i] != 8'hFF) r_lost[i] <= r_lost[i] + 8'd1;
      end
    end
  end

  // Pack counters onto the flat output bus
  always_comb begin
    LOST_COUNT = '0;
    for (int i = 0; i < NCH; i++) LOST_COUNT[8*i +: 8] = r_lost[i];
  end
`else
  assign LOST_COUNT = '0;
`endif

  assign FIFO_EMPTY           = !r_out_valid;
  assign FIFO_DATA            = r_out_data;
  assign RX_FIFO_FULL         = r_full;
  assign RX_FIFO_OVERFLOW_ERR = r_ovf;
  assign RX_FRAME_ERR         = r_ferr;

endmodule
